// File: rtl/exec_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the execute stage.
// Shift-add multiply / restoring divide, one bit per cycle, then a sign-fix
// cycle that writes the architectural HI/LO registers and pulses done.
`timescale 1ns/1ps
module exec_muldiv_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [DATA_WIDTH-1:0]      rs_in,
  input  logic [DATA_WIDTH-1:0]      rt_in,
  input  logic [FREE_LIST_WIDTH-1:0] tag_in,
  input  logic                       hi_we,
  input  logic                       lo_we,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       busy,
  output logic                       stall_req,
  output logic                       done,
  output logic [FREE_LIST_WIDTH-1:0] tag_out,
  output logic [DATA_WIDTH-1:0]      hi_out,
  output logic [DATA_WIDTH-1:0]      lo_out
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 op_q, op_d;
  logic [FREE_LIST_WIDTH-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              acc_hi_q, acc_hi_d;   // partial product / remainder
  logic [DW-1:0]              acc_lo_q, acc_lo_d;   // multiplier / quotient
  logic [DW-1:0]              mcand_q, mcand_d;     // multiplicand / divisor magnitude
  logic                       sa_q, sa_d, sb_q, sb_d;
  logic [DW-1:0]              hi_q, hi_d, lo_q, lo_d;
  logic                       done_q, done_d;

  // op[0]==0 selects the signed variants; signs are only recorded for those
  logic          is_signed;
  logic [DW-1:0] rs_mag, rt_mag;
  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed & rs_in[DW-1]) ? -rs_in : rs_in;
  assign rt_mag    = (is_signed & rt_in[DW-1]) ? -rt_in : rt_in;

  // multiply step: conditionally add, then shift {carry,hi,lo} right by one
  logic [DW:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mcand_q : '0)};

  // divide step: shift in next dividend bit, subtract divisor if it fits
  logic [DW:0]   div_shift;
  logic [DW-1:0] div_sub;
  logic          div_ge;
  assign div_shift = {acc_hi_q, acc_lo_q[DW-1]};
  assign div_sub   = div_shift[DW-1:0] - mcand_q;
  assign div_ge    = (div_shift >= {1'b0, mcand_q});

  // sign correction applied in FIX; unsigned ops carry zero sign flags
  logic [2*DW-1:0] prod, mul_res;
  logic [DW-1:0]   quo, rem;
  logic            neg_res;
  assign neg_res = sa_q ^ sb_q;
  assign prod    = {acc_hi_q, acc_lo_q};
  assign mul_res = neg_res ? -prod : prod;
  // divide by zero: all-ones quotient; remainder naturally ends as the dividend
  assign quo     = (mcand_q == '0) ? '1 : (neg_res ? -acc_lo_q : acc_lo_q);
  assign rem     = sa_q ? -acc_hi_q : acc_hi_q;

  // next-state: FSM, iteration datapath and HI/LO writes
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    tag_out_d = tag_out_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d  = CALC;
          op_d     = op;
          tag_d    = tag_in;
          cnt_d    = '0;
          sa_d     = is_signed & rs_in[DW-1];
          sb_d     = is_signed & rt_in[DW-1];
          acc_hi_d = '0;
          if (op[1]) begin
            acc_lo_d = rs_mag;
            mcand_d  = rt_mag;
          end else begin
            acc_lo_d = rt_mag;
            mcand_d  = rs_mag;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[1]) begin
            acc_hi_d = div_ge ? div_sub : div_shift[DW-1:0];
            acc_lo_d = {acc_lo_q[DW-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[DW:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[DW-1:1]};
          end
          if (cnt_q == CW'(DW-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d    = 1'b1;
          tag_out_d = tag_q;
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = mul_res[2*DW-1:DW];
            lo_d = mul_res[DW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      tag_out_q <= tag_out_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  // stall in the same cycle start is presented so upstream holds immediately
  assign stall_req = busy | (start & ~flush & (state_q == IDLE));
  assign done      = done_q;
  assign tag_out   = tag_out_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: latency, results, corner divides,
// MTHI/MTLO, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_exec_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n, flush, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_in, rt_in, wdata;
  logic [2:0]  tag_in;
  logic        busy, stall_req, done;
  logic [2:0]  tag_out;
  logic [31:0] hi_out, lo_out;

  int vectors = 0;
  int miscompares = 0;

  exec_muldiv_unit #(.DATA_WIDTH(32), .FREE_LIST_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
    .rs_in(rs_in), .rt_in(rt_in), .tag_in(tag_in), .hi_we(hi_we),
    .lo_we(lo_we), .wdata(wdata), .busy(busy), .stall_req(stall_req),
    .done(done), .tag_out(tag_out), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // entered and left at posedge+1
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] t,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    bit busy_bad;
    op = o; rs_in = a; rt_in = b; tag_in = t; start = 1'b1;
    #1;
    vectors++;
    if (stall_req !== 1'b1) begin
      miscompares++; $display("FAIL %s stall_req_on_start got=%b exp=1", nm, stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    vectors++;
    if (lat != 33) begin
      miscompares++; $display("FAIL %s latency got=%0d exp=33", nm, lat);
    end
    vectors++;
    if (busy_bad) begin
      miscompares++; $display("FAIL %s busy_during_op got=dropped exp=held", nm);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL %s busy_at_done got=%b exp=0", nm, busy);
    end
    vectors++;
    if (hi_out !== exp_hi) begin
      miscompares++; $display("FAIL %s hi got=%h exp=%h", nm, hi_out, exp_hi);
    end
    vectors++;
    if (lo_out !== exp_lo) begin
      miscompares++; $display("FAIL %s lo got=%h exp=%h", nm, lo_out, exp_lo);
    end
    vectors++;
    if (tag_out !== t) begin
      miscompares++; $display("FAIL %s tag got=%0d exp=%0d", nm, tag_out, t);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL %s done_clear got=%b exp=0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs_in = '0; rt_in = '0; wdata = '0; tag_in = '0;
    #12;
    vectors++;
    if ({busy, done, stall_req} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got=%b exp=000", {busy, done, stall_req});
    end
    vectors++;
    if ({hi_out, lo_out, tag_out} !== 67'd0) begin
      miscompares++; $display("FAIL reset_regs got=%h/%h/%0d exp=0", hi_out, lo_out, tag_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'hFFFFFFFE, 32'h00000001);
  endtask

  task automatic test_mult_div();
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",  2'b10, 32'hFFFFFFF9, 32'd2, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",     2'b11, 32'd100,      32'd7, 3'd4, 32'd2,        32'd14);
  endtask

  task automatic test_div_corner();
    run_op("divu_zero", 2'b11, 32'h12345678, 32'd0,        3'd7, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 3'd3, 32'd0,        32'h80000000);
  endtask

  task automatic test_mthi_flush();
    bit saw_done;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00000055;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    vectors++;
    if ({hi_out, lo_out} !== {32'h55, 32'h55}) begin
      miscompares++; $display("FAIL mthi_mtlo_both got=%h/%h exp=55/55", hi_out, lo_out);
    end
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(posedge clk); #1;
    hi_we = 1'b0;
    vectors++;
    if (hi_out !== 32'hAAAA0000) begin
      miscompares++; $display("FAIL mthi got=%h exp=aaaa0000", hi_out);
    end
    op = 2'b00; rs_in = 32'd5; rt_in = 32'd6; tag_in = 3'd6; start = 1'b1;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (2) @(posedge clk); #1;      // after E2
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;                 // after E3
    hi_we = 1'b0;
    vectors++;
    if (hi_out !== 32'hAAAA0000) begin
      miscompares++; $display("FAIL mthi_while_busy got=%h exp=aaaa0000", hi_out);
    end
    repeat (7) @(posedge clk); #1;      // after E10
    flush = 1'b1;
    @(posedge clk); #1;                 // after E11
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy got=%b exp=0", busy);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++; $display("FAIL flush_no_done got=pulse exp=none");
    end
    vectors++;
    if ({hi_out, lo_out} !== {32'hAAAA0000, 32'h55}) begin
      miscompares++; $display("FAIL flush_hilo got=%h/%h exp=aaaa0000/55", hi_out, lo_out);
    end
  endtask

  task automatic test_start_flush();
    op = 2'b01; rs_in = 32'd9; rt_in = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    vectors++;
    if (stall_req !== 1'b0) begin
      miscompares++; $display("FAIL start_flush_stall got=%b exp=0", stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL start_flush_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    op = 2'b10; rs_in = 32'hFFFFFFF9; rt_in = 32'd2; tag_in = 3'd6; start = 1'b1;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (15) @(posedge clk); #1;     // after E15
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL midreset_flags got=%b exp=00", {busy, done});
    end
    vectors++;
    if ({hi_out, lo_out, tag_out} !== 67'd0) begin
      miscompares++; $display("FAIL midreset_regs got=%h/%h/%0d exp=0", hi_out, lo_out, tag_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu_after_reset", 2'b01, 32'd3, 32'd4, 3'd2, 32'd0, 32'd12);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_div();
    test_div_corner();
    test_mthi_flush();
    test_start_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the decode-to-execute pipeline register.
- Consumes the registered alu_rs/alu_rt operands and the active-list tag, computes MULT/MULTU/DIV/DIVU into HI/LO over 33 cycles, and owns the architectural HI/LO registers.
- Raises stall_req so the decode-to-execute register and earlier stages hold while it is busy.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.
- FREE_LIST_WIDTH, 3, width of the active-list index tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort any operation in flight; suppress start
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_in  in  DATA_WIDTH  multiplicand / dividend
- rt_in  in  DATA_WIDTH  multiplier / divisor
- tag_in  in  FREE_LIST_WIDTH  active-list index of the launching instruction
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  DATA_WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- stall_req  out  1  pipeline hold request
- done  out  1  one-cycle completion pulse
- tag_out  out  FREE_LIST_WIDTH  tag of the completed operation
- hi_out  out  DATA_WIDTH  HI register
- lo_out  out  DATA_WIDTH  LO register

Behaviour:
- Reset is asynchronous, active-low rst_n; clock is clk. While reset is asserted:
  - state = IDLE
  - busy, done = 0
  - hi_out, lo_out, tag_out = 0
  - counter and datapath registers = 0
- States:
  - IDLE -> CALC on start & ~flush. Capture op and tag; load |rs|, |rt| for signed ops, raw values for unsigned; record sign bits; clear counter.
  - CALC: one iteration per edge (shift-add multiply, or restoring divide one quotient bit). Counter increments. Counter == DATA_WIDTH-1 at the edge -> FIX.
  - FIX: apply sign correction, write HI/LO, set done = 1, tag_out = captured tag, go to IDLE.
- Latency: start sampled at edge E0; iterations on E1..E32; HI/LO update and done rise at E33; done clears at E34. done is high for exactly one cycle.
- busy = (state != IDLE), registered-state decode.
- stall_req = busy | (start & ~flush & state == IDLE), combinational, so the stall is asserted in the same cycle start is presented.
- start while busy is ignored (the stall prevents it from occurring).
- Multiply results:
  - MULTU: {HI,LO} = 64-bit unsigned product.
  - MULT: magnitude product, negated in FIX if the operand signs differ.
- Divide results:
  - LO = quotient, HI = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (any DIV/DIVU): same latency; LO = 0xFFFFFFFF, HI = rs_in as captured. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- flush:
  - In CALC or FIX: next edge returns to IDLE; HI/LO unchanged; done stays 0.
  - In IDLE with start: start is ignored.
- hi_we / lo_we:
  - Honoured only in IDLE; update on the next edge.
  - Ignored while busy.
  - Both set in the same cycle: both registers take wdata.
- done and hi_we never coincide, because FIX is a busy state.
- Reset mid-operation: immediate return to the reset values; the operation is lost.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF tag=5, start at E0 -> busy E0..E33; done pulse at E33 only; HI=0xFFFFFFFE, LO=0x00000001, tag_out=5.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- DIVU rs=0x12345678 rt=0 -> done at E33; LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA0000 in IDLE -> HI updated next edge. Launch MULT, assert flush at E10 -> busy=0 after E11; no done pulse; HI still 0xAAAA0000.
- start with flush in the same cycle -> busy stays 0 and stall_req=0. start alone -> stall_req=1 in the same cycle.
- rst_n low at E15 of a DIV -> busy, done, HI, LO, tag_out all 0 immediately. New MULTU 3*4 after release -> LO=12, HI=0 at +33 edges.
